// File: rtl/shift_register_tx_pkg.sv
// Shared types and constants for the serial shift-register link transmitter.
package shift_register_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam logic DATA_RESET = 1'b0;

endpackage

// File: rtl/shift_register_tx.sv
// Parallel-in/serial-out transmitter paced by a shared shift_enable strobe.
// Optional even-parity trailer bit when SHIFT_REGISTER_TX_PARITY_EN is defined.
module shift_register_tx
  import shift_register_tx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_enable,
  output logic             data,
  output logic             data_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state_reg;
  logic [WIDTH-1:0]   shreg_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               data_reg;
  logic               data_valid_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               load_ready_reg;
`ifdef SHIFT_REGISTER_TX_PARITY_EN
  logic               parity_reg;
`endif

  logic [WIDTH-1:0]   shifted;
  logic               next_bit;
  logic               first_bit;
  logic               last_bit;

  // The bit presented after a shift is the neighbour of the one just consumed.
  assign shifted   = MSB_FIRST ? {shreg_reg[WIDTH-2:0], 1'b0} : {1'b0, shreg_reg[WIDTH-1:1]};
  assign next_bit  = MSB_FIRST ? shreg_reg[WIDTH-2] : shreg_reg[1];
  assign first_bit = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
  assign last_bit  = (count_reg == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      shreg_reg      <= '0;
      count_reg      <= '0;
      data_reg       <= DATA_RESET;
      data_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      load_ready_reg <= 1'b1;
`ifdef SHIFT_REGISTER_TX_PARITY_EN
      parity_reg     <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (load_valid) begin
            state_reg      <= SHIFT;
            shreg_reg      <= load_data;
            count_reg      <= '0;
            data_reg       <= first_bit;
            data_valid_reg <= 1'b1;
            busy_reg       <= 1'b1;
            load_ready_reg <= 1'b0;
`ifdef SHIFT_REGISTER_TX_PARITY_EN
            parity_reg     <= ^load_data;
`endif
          end
        end
        SHIFT: begin
          if (shift_enable) begin
            shreg_reg <= shifted;
            if (last_bit) begin
`ifdef SHIFT_REGISTER_TX_PARITY_EN
              state_reg      <= PARITY;
              data_reg       <= parity_reg;
`else
              state_reg      <= IDLE;
              data_reg       <= DATA_RESET;
              data_valid_reg <= 1'b0;
              busy_reg       <= 1'b0;
              done_reg       <= 1'b1;
              load_ready_reg <= 1'b1;
`endif
            end else begin
              count_reg <= count_reg + 1'b1;
              data_reg  <= next_bit;
            end
          end
        end
`ifdef SHIFT_REGISTER_TX_PARITY_EN
        PARITY: begin
          if (shift_enable) begin
            state_reg      <= IDLE;
            data_reg       <= DATA_RESET;
            data_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b1;
            load_ready_reg <= 1'b1;
          end
        end
`endif
        default: begin
          state_reg      <= IDLE;
          data_reg       <= DATA_RESET;
          data_valid_reg <= 1'b0;
          busy_reg       <= 1'b0;
          load_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign data       = data_reg;
  assign data_valid = data_valid_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign load_ready = load_ready_reg;

endmodule

// File: tb/tb_shift_register_tx.sv
// Randomized bench for shift_register_tx: MSB-first and LSB-first instances share stimulus,
// each checked against a bit-index model and a loopback receiver model.
module tb_shift_register_tx;

`ifdef SHIFT_REGISTER_TX_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] load_data = '0;
  logic       load_valid = 1'b0;
  logic       shift_enable = 1'b0;

  logic ready_m, data_m, dv_m, busy_m, done_m;
  logic ready_l, data_l, dv_l, busy_l, done_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_register_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
    .load_ready(ready_m), .shift_enable(shift_enable), .data(data_m),
    .data_valid(dv_m), .busy(busy_m), .done(done_m)
  );

  shift_register_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
    .load_ready(ready_l), .shift_enable(shift_enable), .data(data_l),
    .data_valid(dv_l), .busy(busy_l), .done(done_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bit k of the frame as the receiver should see it.
  function automatic logic exp_bit(input logic [7:0] w, input int k, input bit msb);
    if (k >= 8) return ^w;
    return msb ? w[7-k] : w[k];
  endfunction

  function automatic logic [7:0] reverse8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, {ready_m, ready_l}, 2'b11);
    check({tag, "_data"},  {data_m, data_l}, 2'b00);
    check({tag, "_dv"},    {dv_m, dv_l}, 2'b00);
    check({tag, "_busy"},  {busy_m, busy_l}, 2'b00);
    check({tag, "_done"},  {done_m, done_l}, 2'b00);
  endtask

  // Called at a negedge; returns at the negedge right after the done cycle begins.
  task automatic do_frame(input logic [7:0] w, input int stall_pct, input bit junk,
                          input logic [7:0] junk_word);
    int k, cycles, enabled;
    logic [7:0] rx_m, rx_l;
    bit se;
    check("ld_ready", {ready_m, ready_l}, 2'b11);
    load_data  = w;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    k = 0; cycles = 0; enabled = 0; rx_m = '0; rx_l = '0;
    while (k < FRAME && cycles < 400) begin
      check("m_bit", data_m, exp_bit(w, k, 1'b1));
      check("l_bit", data_l, exp_bit(w, k, 1'b0));
      check("active", {dv_m, busy_m, ready_m, done_m, dv_l, busy_l, ready_l, done_l},
            8'b1100_1100);
      se = ($urandom_range(99) >= stall_pct);
      shift_enable = se;
      if (junk) begin
        load_valid = $urandom_range(1);
        load_data  = junk_word;
      end
      if (se && k < 8) begin
        rx_m = {rx_m[6:0], data_m};
        rx_l = {rx_l[6:0], data_l};
      end
      @(negedge clk);
      if (se) k++;
      cycles++;
    end
    shift_enable = 1'b0;
    load_valid   = 1'b0;
    check("frame_len", k, FRAME);
    check("m_rx", rx_m, w);
    check("l_rx", rx_l, reverse8(w));
    check("fin_done", {done_m, done_l}, 2'b11);
    check("fin_ready", {ready_m, ready_l}, 2'b11);
    check("fin_out", {data_m, dv_m, busy_m, data_l, dv_l, busy_l}, 6'b0);
    $display("frame %02h stall=%0d junk=%0d cycles=%0d bits=%0d", w, stall_pct, junk, cycles, k);
  endtask

  task automatic idle_cycle();
    shift_enable = $urandom_range(1);
    @(negedge clk);
    shift_enable = 1'b0;
    check_idle("idle");
  endtask

  initial begin
    // Reset held for 3 cycles
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("rst");
    reset = 1'b1;
    @(negedge clk);

    do_frame(8'hA5, 0, 1'b0, 8'h00);
    idle_cycle();
    do_frame(8'h81, 50, 1'b0, 8'h00);
    idle_cycle();
    do_frame(8'hF0, 30, 1'b1, 8'h0F);
    do_frame(8'h0F, 0, 1'b0, 8'h00);   // captured in the done cycle
    idle_cycle();
    do_frame(8'h01, 0, 1'b0, 8'h00);
    do_frame(8'h07, 20, 1'b0, 8'h00);
    do_frame(8'h03, 20, 1'b0, 8'h00);
    idle_cycle();

    // Abort mid-frame via asynchronous reset
    load_data = 8'hFF; load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0; shift_enable = 1'b1;
    repeat (3) @(negedge clk);
    shift_enable = 1'b0;
    check("abort_pre_dv", {dv_m, dv_l}, 2'b11);
    #2 reset = 1'b0;
    #1;
    check("abort_out", {data_m, dv_m, busy_m, data_l, dv_l, busy_l}, 6'b0);
    check("abort_ready", {ready_m, ready_l}, 2'b11);
    shift_enable = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("abort_nodone", {done_m, done_l}, 2'b00);
    end
    shift_enable = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_idle("post_abort");
    $display("abort after 3 bits of ff");
    do_frame(8'h3C, 0, 1'b0, 8'h00);

    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(1)) idle_cycle();
      do_frame(8'($urandom), $urandom_range(70), 1'($urandom_range(1)), 8'($urandom));
    end
    @(negedge clk);
    check_idle("end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
